// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and a small
// first-word-fall-through receive FIFO. Framing errors and overruns are
// reported as single-cycle pulses; a framing-error byte is never stored.
module uart_rx_fifo #(
  parameter int CLK_DIV    = 5,  // clk cycles per oversample tick
  parameter int FIFO_DEPTH = 4   // receive FIFO entries, power of two >= 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       rx_rd_en,
  output logic [7:0] rx_data_out,
  output logic       rx_valid,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer, edge detect and start arming
  // ---------------------------------------------------------------------------
  logic       rxd_meta_q;
  logic       rs_q;
  logic       rs_prev_q;
  logic [1:0] warm_q;
  logic       armed_q;
  logic       start_det;

  // Two-flop synchronizer plus a history flop; idle-high reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rs_q       <= 1'b1;
      rs_prev_q  <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rs_q       <= rxd_meta_q;
      rs_prev_q  <= rs_q;
    end
  end

  // The synchronizer holds reset values (not the line) for two cycles after
  // release; a start is only allowed once a real high level has been seen,
  // so a line that is low at release cannot fake a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      warm_q  <= {warm_q[0], 1'b1};
      armed_q <= armed_q | (warm_q[1] & rs_q);
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick generator, re-phased on every start detection
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic             tick;

  assign start_det = (state_q == S_IDLE) && armed_q && rs_prev_q && !rs_q;
  assign tick      = (div_q == DIV_LAST);

  // Free-running divider; cleared on start so ticks align to the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (start_det || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [3:0] sample_cnt_q, sample_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic       push_req;
  logic       frame_err_d;
  logic       frame_err_q;

  // State, tick count, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sample_cnt_q <= 4'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Next-state logic: mid-start check at tick 8, then every 16 ticks.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    push_req     = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_det) begin
          state_d      = S_START;
          sample_cnt_d = 4'd0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sample_cnt_q == 4'd7) begin
            sample_cnt_d = 4'd0;
            bit_idx_d    = 3'd0;
            // A line back high at mid start bit was only a glitch.
            state_d      = rs_q ? S_IDLE : S_DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (sample_cnt_q == 4'd15) begin
            sample_cnt_d = 4'd0;
            shift_d      = {rs_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (sample_cnt_q == 4'd15) begin
            sample_cnt_d = 4'd0;
            if (rs_q) begin
              push_req = 1'b1;
              state_d  = S_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = S_BREAK;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 4'd1;
          end
        end
      end
      S_BREAK: begin
        // Hold here through a break so it is flagged only once.
        if (rs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through receive FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_d;
  logic             overrun_q;
  logic             fifo_full;
  logic             fifo_nonempty;
  logic             pop;
  logic             push_ok;

  assign fifo_full     = (count_q == FULL_CNT);
  assign fifo_nonempty = (count_q != '0);
  assign pop           = rx_rd_en && fifo_nonempty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign push_ok       = push_req && (!fifo_full || pop);

  // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = push_req && fifo_full && !pop;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers and the registered overrun pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage array; contents are qualified by count so need no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign rx_data_out = fifo_nonempty ? mem_q[rd_ptr_q] : 8'h00;
  assign rx_valid    = fifo_nonempty;
  assign rx_empty    = !fifo_nonempty;
  assign rx_full     = fifo_full;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule
